// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Control-flow opcodes, the invalid ROB tag, and the reservation
//            entry / resolved-result structures for the branch unit.
// Revision : 1.0
// ============================================================================
package lc3b_types;

    localparam logic [3:0] CF_JUMP   = 4'd0;
    localparam logic [3:0] CF_JSR    = 4'd1;
    localparam logic [3:0] CF_JSRR   = 4'd2;
    localparam logic [3:0] CF_BRANCH = 4'd3;

    // Tags are stored at a fixed maximum width; a narrower ROB all-ones tag
    // is widened to TAG_INVALID so that "ready" is a single comparison.
    localparam int TAG_W_MAX = 8;
    typedef logic [TAG_W_MAX-1:0] tag_t;
    localparam tag_t TAG_INVALID = '1;

    typedef struct packed {
        logic        busy;
        logic [3:0]  op;
        logic [15:0] pc;
        logic [15:0] vj;
        logic [15:0] vk;
        tag_t        qj;
        tag_t        qk;
        tag_t        dest;
        logic        pred;
        logic [3:0]  age;
    } entry_t;

    typedef struct packed {
        logic        taken;
        logic [15:0] target;
        logic [15:0] value;
        logic        update_pc;
        logic [15:0] new_pc;
    } res_t;

    function automatic tag_t widen_tag(input tag_t t, input int w);
        return (t == tag_t'((1 << w) - 1)) ? TAG_INVALID : t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cf_resolve.sv
`default_nettype none
// ============================================================================
// Module   : cf_resolve
// Purpose  : Combinational control-flow resolution (direction, target, link).
//            BRANCH_PREDICTION_EN: redirect only on mispredict.
// Revision : 1.0
// ============================================================================
module cf_resolve
    import lc3b_types::*;
(
    input  logic [3:0]  i_op,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_vj,
    input  logic [15:0] i_vk,
`ifdef BRANCH_PREDICTION_EN
    input  logic        i_pred,
`endif
    output res_t        o_res
);

    logic [15:0] w_pc2;
    logic [15:0] w_br_off;
    logic        w_br_taken;

    always_comb begin
        w_pc2      = i_pc + 16'd2;
        w_br_off   = {{6{i_vk[8]}}, i_vk[8:0], 1'b0};
        w_br_taken = (i_vk[11] & i_vj[15])
                   | (i_vk[10] & (i_vj == 16'd0))
                   | (i_vk[9] & ~i_vj[15] & (i_vj != 16'd0));
        o_res = '0;
        case (i_op)
            CF_JUMP: begin
                o_res.taken  = 1'b1;
                o_res.target = i_vj;
            end
            CF_JSR: begin
                o_res.taken  = 1'b1;
                o_res.target = w_pc2 + i_vj;
                o_res.value  = w_pc2;
            end
            CF_JSRR: begin
                o_res.taken  = 1'b1;
                o_res.target = i_vj;
                o_res.value  = w_pc2;
            end
            CF_BRANCH: begin
                o_res.taken  = w_br_taken;
                o_res.target = w_pc2 + w_br_off;
            end
            default: ;
        endcase
        o_res.new_pc = o_res.taken ? o_res.target : w_pc2;
`ifdef BRANCH_PREDICTION_EN
        o_res.update_pc = o_res.taken ^ i_pred;
`else
        o_res.update_pc = o_res.taken;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_exec_unit
// Purpose  : Control-flow reservation stations with CDB wakeup, oldest-ready
//            select and a one-deep result register. Macro: BRANCH_PREDICTION_EN.
// Revision : 1.0
// ============================================================================
module branch_exec_unit
    import lc3b_types::*;
#(
    parameter int NUM_STATIONS = 4,
    parameter int ROB_ID_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [3:0]                        issue_op,
    input  logic [15:0]                       issue_pc,
    input  logic [15:0]                       issue_vj,
    input  logic [15:0]                       issue_vk,
    input  logic [ROB_ID_W-1:0]               issue_qj,
    input  logic [ROB_ID_W-1:0]               issue_qk,
    input  logic [ROB_ID_W-1:0]               issue_dest,
    input  logic                              issue_pred,
    input  logic                              cdb_valid,
    input  logic [ROB_ID_W-1:0]               cdb_tag,
    input  logic [15:0]                       cdb_value,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROB_ID_W-1:0]               out_dest,
    output logic [15:0]                       out_value,
    output logic                              out_update_pc,
    output logic [15:0]                       out_new_pc,
    output logic                              cf_update,
    output logic [15:0]                       cf_pc,
    output logic [15:0]                       cf_target,
    output logic [3:0]                        cf_op,
    output logic                              cf_taken,
    output logic [$clog2(NUM_STATIONS+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(NUM_STATIONS + 1);
    localparam int IDX_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1;

    entry_t ent_q [NUM_STATIONS];
    entry_t ent_d [NUM_STATIONS];
    logic                out_valid_q, out_valid_d;
    res_t                res_q, res_d;
    logic [ROB_ID_W-1:0] dest_q, dest_d;
    logic [15:0]         pc_q, pc_d;
    logic [3:0]          op_q, op_d;

    logic [NUM_STATIONS-1:0] w_rdy;
    logic [OCC_W-1:0]        w_occ;
    logic                    w_sel_found, w_sel_fire, w_alloc_found, w_issue_fire;
    logic [IDX_W-1:0]        w_sel_idx, w_alloc_idx;
    logic [3:0]              w_sel_age;
    tag_t                    w_cdb_tag;
    entry_t                  w_new_ent;
    res_t                    w_res;

    // Occupancy, oldest-ready select (smallest age) and lowest free slot.
    always_comb begin
        w_rdy         = '0;
        w_occ         = '0;
        w_sel_found   = 1'b0;
        w_sel_idx     = '0;
        w_sel_age     = '0;
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            w_rdy[i] = ent_q[i].busy && (ent_q[i].qj == TAG_INVALID) && (ent_q[i].qk == TAG_INVALID);
            if (ent_q[i].busy) w_occ = w_occ + OCC_W'(1);
            if (w_rdy[i] && (!w_sel_found || (ent_q[i].age < w_sel_age))) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
                w_sel_age   = ent_q[i].age;
            end
            if (!ent_q[i].busy && !w_alloc_found) begin
                w_alloc_found = 1'b1;
                w_alloc_idx   = IDX_W'(i);
            end
        end
        issue_ready  = (w_occ < OCC_W'(NUM_STATIONS));
        w_issue_fire = issue_valid && issue_ready;
        w_sel_fire   = w_sel_found && (!out_valid_q || out_ready);
        w_cdb_tag    = widen_tag(tag_t'(cdb_tag), ROB_ID_W);
    end

    // Incoming entry, including a same-cycle CDB bypass on either operand.
    always_comb begin
        w_new_ent      = '0;
        w_new_ent.busy = 1'b1;
        w_new_ent.op   = issue_op;
        w_new_ent.pc   = issue_pc;
        w_new_ent.vj   = issue_vj;
        w_new_ent.vk   = issue_vk;
        w_new_ent.qj   = widen_tag(tag_t'(issue_qj), ROB_ID_W);
        w_new_ent.qk   = widen_tag(tag_t'(issue_qk), ROB_ID_W);
        w_new_ent.dest = tag_t'(issue_dest);
`ifdef BRANCH_PREDICTION_EN
        w_new_ent.pred = issue_pred;
`else
        w_new_ent.pred = 1'b0;
`endif
        w_new_ent.age  = 4'(w_occ - OCC_W'(w_sel_fire));
        if (cdb_valid && (w_new_ent.qj != TAG_INVALID) && (w_new_ent.qj == w_cdb_tag)) begin
            w_new_ent.vj = cdb_value;
            w_new_ent.qj = TAG_INVALID;
        end
        if (cdb_valid && (w_new_ent.qk != TAG_INVALID) && (w_new_ent.qk == w_cdb_tag)) begin
            w_new_ent.vk = cdb_value;
            w_new_ent.qk = TAG_INVALID;
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < NUM_STATIONS; i++) begin
            if (ent_q[i].busy && cdb_valid) begin
                if ((ent_q[i].qj != TAG_INVALID) && (ent_q[i].qj == w_cdb_tag)) begin
                    ent_d[i].vj = cdb_value;
                    ent_d[i].qj = TAG_INVALID;
                end
                if ((ent_q[i].qk != TAG_INVALID) && (ent_q[i].qk == w_cdb_tag)) begin
                    ent_d[i].vk = cdb_value;
                    ent_d[i].qk = TAG_INVALID;
                end
            end
            // Survivors younger than the departing entry close the age gap.
            if (w_sel_fire) begin
                if (IDX_W'(i) == w_sel_idx) begin
                    ent_d[i] = '0;
                end else if (ent_q[i].busy && (ent_q[i].age > w_sel_age)) begin
                    ent_d[i].age = ent_q[i].age - 4'd1;
                end
            end
        end
        if (w_issue_fire) ent_d[w_alloc_idx] = w_new_ent;
        if (flush) begin
            for (int i = 0; i < NUM_STATIONS; i++) ent_d[i] = '0;
        end
    end

    cf_resolve u_cf_resolve (
        .i_op   (ent_q[w_sel_idx].op),
        .i_pc   (ent_q[w_sel_idx].pc),
        .i_vj   (ent_q[w_sel_idx].vj),
        .i_vk   (ent_q[w_sel_idx].vk),
`ifdef BRANCH_PREDICTION_EN
        .i_pred (ent_q[w_sel_idx].pred),
`endif
        .o_res  (w_res)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        res_d       = res_q;
        dest_d      = dest_q;
        pc_d        = pc_q;
        op_d        = op_q;
        if (w_sel_fire) begin
            out_valid_d = 1'b1;
            res_d       = w_res;
            dest_d      = ent_q[w_sel_idx].dest[ROB_ID_W-1:0];
            pc_d        = ent_q[w_sel_idx].pc;
            op_d        = ent_q[w_sel_idx].op;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATIONS; i++) ent_q[i] <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            dest_q      <= '0;
            pc_q        <= '0;
            op_q        <= '0;
        end else begin
            ent_q       <= ent_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            dest_q      <= dest_d;
            pc_q        <= pc_d;
            op_q        <= op_d;
        end
    end

    assign occupancy     = w_occ;
    assign out_valid     = out_valid_q;
    assign out_dest      = dest_q;
    assign out_value     = res_q.value;
    assign out_update_pc = res_q.update_pc;
    assign out_new_pc    = res_q.new_pc;
    assign cf_update     = out_valid_q && out_ready;
    assign cf_pc         = pc_q;
    assign cf_target     = res_q.target;
    assign cf_op         = op_q;
    assign cf_taken      = res_q.taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_exec_unit
// Purpose  : Directed-vector scoreboard bench for branch_exec_unit.
// Revision : 1.0
// ============================================================================
module tb_branch_exec_unit;

    localparam int N  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_ready;
    logic [3:0]    issue_op = '0;
    logic [15:0]   issue_pc = '0, issue_vj = '0, issue_vk = '0;
    logic [TW-1:0] issue_qj = '1, issue_qk = '1, issue_dest = '0;
    logic          issue_pred = 1'b0;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [15:0]   cdb_value = '0;
    logic          out_valid, out_ready, out_update_pc, cf_update, cf_taken;
    logic [TW-1:0] out_dest;
    logic [15:0]   out_value, out_new_pc, cf_pc, cf_target;
    logic [3:0]    cf_op;
    logic [$clog2(N+1)-1:0] occupancy;

    always #5 clk = ~clk;

    branch_exec_unit #(.NUM_STATIONS(N), .ROB_ID_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_pc(issue_pc), .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_dest(issue_dest),
        .issue_pred(issue_pred), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_dest(out_dest), .out_value(out_value), .out_update_pc(out_update_pc),
        .out_new_pc(out_new_pc), .cf_update(cf_update), .cf_pc(cf_pc),
        .cf_target(cf_target), .cf_op(cf_op), .cf_taken(cf_taken),
        .occupancy(occupancy)
    );

    typedef struct packed {
        logic [TW-1:0] dest;
        logic [15:0]   value;
        logic          upd;
        logic [15:0]   new_pc;
        logic [15:0]   pc;
        logic [15:0]   target;
        logic [3:0]    op;
        logic          taken;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor: every accepted result is popped and compared.
    always @(negedge clk) begin
        exp_t act;
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            act = {out_dest, out_value, out_update_pc, out_new_pc, cf_pc, cf_target, cf_op, cf_taken};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: actual dest=%h new_pc=%h, required no output", out_dest, out_new_pc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e || cf_update !== 1'b1) begin
                    errors++;
                    $display("FAIL result dest=%h: actual %h cf_update=%b, required %h cf_update=1", e.dest, act, cf_update, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_res(input logic [TW-1:0] dest, input logic [3:0] op, input logic [15:0] pc,
                              input logic [15:0] target, input logic [15:0] value, input logic [15:0] new_pc,
                              input logic taken, input logic upd);
        exp_q.push_back({dest, value, upd, new_pc, pc, target, op, taken});
    endtask

    task automatic do_issue(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] vj,
                            input logic [15:0] vk, input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                            input logic [TW-1:0] dest, input logic acc);
        issue_valid = 1'b1; issue_op = op; issue_pc = pc; issue_vj = vj; issue_vk = vk;
        issue_qj = qj; issue_qk = qk; issue_dest = dest;
        check("issue_ready", 32'(issue_ready), 32'(acc));
        tick(1);
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [TW-1:0] tag, input logic [15:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
        tick(1);
        cdb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        out_ready = 1'b1;
        #12;
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_cf_update", 32'(cf_update), 0);
        check("rst_new_pc", 32'(out_new_pc), 0);
        @(negedge clk); rst_n = 1'b1;
        tick(1);

        // Taken branch with one-cycle select-to-output latency
        expect_res(4'h1, 4'd3, 16'h3000, 16'h3022, 16'h0000, 16'h3022, 1'b1, 1'b1);
        do_issue(4'd3, 16'h3000, 16'h0000, 16'h0E10, 4'hF, 4'hF, 4'h1, 1'b1);
        check("latency_pre", 32'(out_valid), 0);
        tick(1);
        check("latency_valid", 32'(out_valid), 1);
        check("latency_new_pc", 32'(out_new_pc), 32'h3022);
        tick(2);

        // Back-to-back vectors: not-taken, wrap, negative offset, JUMP, JSR, other
        expect_res(4'h2, 4'd3, 16'h3000, 16'h3004, 16'h0000, 16'h3002, 1'b0, 1'b0);
        do_issue(4'd3, 16'h3000, 16'h0005, 16'h0801, 4'hF, 4'hF, 4'h2, 1'b1);
        expect_res(4'h3, 4'd3, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
        do_issue(4'd3, 16'hFFFE, 16'h0000, 16'h0E00, 4'hF, 4'hF, 4'h3, 1'b1);
        expect_res(4'h4, 4'd3, 16'h3000, 16'h3000, 16'h0000, 16'h3000, 1'b1, 1'b1);
        do_issue(4'd3, 16'h3000, 16'h8000, 16'h0FFF, 4'hF, 4'hF, 4'h4, 1'b1);
        expect_res(4'h5, 4'd0, 16'h1000, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b1);
        do_issue(4'd0, 16'h1000, 16'h1234, 16'h0000, 4'hF, 4'hF, 4'h5, 1'b1);
        expect_res(4'h6, 4'd1, 16'h2000, 16'h2012, 16'h2002, 16'h2012, 1'b1, 1'b1);
        do_issue(4'd1, 16'h2000, 16'h0010, 16'h0000, 4'hF, 4'hF, 4'h6, 1'b1);
        expect_res(4'h7, 4'd7, 16'h5000, 16'h0000, 16'h0000, 16'h5002, 1'b0, 1'b0);
        do_issue(4'd7, 16'h5000, 16'h1111, 16'h2222, 4'hF, 4'hF, 4'h7, 1'b1);
        tick(3);

        // Issue-cycle CDB bypass
        expect_res(4'h8, 4'd0, 16'h6000, 16'h7777, 16'h0000, 16'h7777, 1'b1, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 4'hA; cdb_value = 16'h7777;
        do_issue(4'd0, 16'h6000, 16'h0000, 16'h0000, 4'hA, 4'hF, 4'h8, 1'b1);
        cdb_valid = 1'b0;
        tick(2);

        // Wakeup of a waiting JSRR
        expect_res(4'h2, 4'd2, 16'h4100, 16'h4000, 16'h4102, 16'h4000, 1'b1, 1'b1);
        do_issue(4'd2, 16'h4100, 16'hDEAD, 16'h0000, 4'h3, 4'hF, 4'h2, 1'b1);
        tick(2);
        check("wakeup_wait", 32'(out_valid), 0);
        cdb(4'h3, 16'h4000);
        tick(2);

        // Age order: ready B overtakes waiting A
        expect_res(4'hA, 4'd0, 16'h0200, 16'h0B00, 16'h0000, 16'h0B00, 1'b1, 1'b1);
        expect_res(4'h9, 4'd0, 16'h0100, 16'h0A00, 16'h0000, 16'h0A00, 1'b1, 1'b1);
        do_issue(4'd0, 16'h0100, 16'h0000, 16'h0000, 4'h5, 4'hF, 4'h9, 1'b1);
        do_issue(4'd0, 16'h0200, 16'h0B00, 16'h0000, 4'hF, 4'hF, 4'hA, 1'b1);
        tick(2);
        cdb(4'h5, 16'h0A00);
        tick(2);

        // Older entry at higher index wins over younger ready entry
        expect_res(4'hB, 4'd0, 16'h0010, 16'h0600, 16'h0000, 16'h0600, 1'b1, 1'b1);
        expect_res(4'hC, 4'd0, 16'h0020, 16'h0700, 16'h0000, 16'h0700, 1'b1, 1'b1);
        expect_res(4'hD, 4'd0, 16'h0030, 16'h0800, 16'h0000, 16'h0800, 1'b1, 1'b1);
        do_issue(4'd0, 16'h0010, 16'h0000, 16'h0000, 4'h7, 4'hF, 4'hB, 1'b1);
        do_issue(4'd0, 16'h0020, 16'h0000, 16'h0000, 4'h8, 4'hF, 4'hC, 1'b1);
        out_ready = 1'b0;
        cdb(4'h7, 16'h0600);
        tick(1);
        check("age_hold_valid", 32'(out_valid), 1);
        do_issue(4'd0, 16'h0030, 16'h0800, 16'h0000, 4'hF, 4'hF, 4'hD, 1'b1);
        cdb(4'h8, 16'h0700);
        tick(2);
        check("hold_dest", 32'(out_dest), 32'hB);
        check("hold_new_pc", 32'(out_new_pc), 32'h0600);
        check("hold_cf_update", 32'(cf_update), 0);
        check("hold_occupancy", 32'(occupancy), 2);
        out_ready = 1'b1;
        tick(4);

        // Fill all stations under backpressure; extra issue is dropped
        out_ready = 1'b0;
        for (int i = 0; i <= N; i++) begin
            expect_res(TW'(i + 1), 4'd0, 16'h0C00, 16'h1100 + 16'(i), 16'h0000, 16'h1100 + 16'(i), 1'b1, 1'b1);
            do_issue(4'd0, 16'h0C00, 16'h1100 + 16'(i), 16'h0000, 4'hF, 4'hF, TW'(i + 1), 1'b1);
        end
        check("full_occupancy", 32'(occupancy), N);
        do_issue(4'd0, 16'h0C00, 16'h9999, 16'h0000, 4'hF, 4'hF, 4'hE, 1'b0);
        check("full_occupancy_after_drop", 32'(occupancy), N);
        check("full_hold_dest", 32'(out_dest), 1);
        check("full_hold_new_pc", 32'(out_new_pc), 32'h1100);
        out_ready = 1'b1;
        tick(8);

        // Flush overrides simultaneous issue and CDB capture
        out_ready = 1'b0;
        do_issue(4'd0, 16'h0D00, 16'h1234, 16'h0000, 4'hF, 4'hF, 4'h2, 1'b1);
        do_issue(4'd0, 16'h0D10, 16'h0000, 16'h0000, 4'h9, 4'hF, 4'h3, 1'b1);
        check("flush_pre_valid", 32'(out_valid), 1);
        flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 4'h9; cdb_value = 16'h5555;
        do_issue(4'd0, 16'h0D20, 16'h4321, 16'h0000, 4'hF, 4'hF, 4'h4, 1'b1);
        flush = 1'b0; cdb_valid = 1'b0;
        check("flush_occupancy", 32'(occupancy), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        check("flush_cf_update", 32'(cf_update), 0);
        tick(5);
        check("flush_idle_occupancy", 32'(occupancy), 0);

        // Asynchronous reset in the middle of traffic
        out_ready = 1'b0;
        do_issue(4'd1, 16'h0E00, 16'h0002, 16'h0000, 4'hF, 4'hF, 4'h5, 1'b1);
        do_issue(4'd0, 16'h0E10, 16'h0000, 16'h0000, 4'h9, 4'hF, 4'h6, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_occupancy", 32'(occupancy), 0);
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_issue_ready", 32'(issue_ready), 1);
        check("mrst_cf_update", 32'(cf_update), 0);
        check("mrst_new_pc", 32'(out_new_pc), 0);
        check("mrst_cf_pc", 32'(cf_pc), 0);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        tick(4);

        // JSR across the 0xFFFE wrap after reset
        expect_res(4'h4, 4'd1, 16'hFFFE, 16'h0010, 16'h0000, 16'h0010, 1'b1, 1'b1);
        do_issue(4'd1, 16'hFFFE, 16'h0010, 16'h0000, 4'hF, 4'hF, 4'h4, 1'b1);

        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick(1);
        tick(2);
        check("drain_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 SHALL have parameter NUM_STATIONS, default 4, number of control-flow reservation entries (legal range 1..16).
REQ-002 SHALL have parameter ROB_ID_W, default 4, ROB tag width; tag value all-ones is the invalid/"operand ready" tag.
REQ-003 SHALL have the ports below, clock and reset first. Clocking is fixed: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush.
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one free entry.
- issue_op  in  4  CF opcode.
- issue_pc  in  16  instruction PC.
- issue_vj, issue_vk  in  16 each  operand values.
- issue_qj, issue_qk  in  ROB_ID_W each  producer tags, invalid = ready.
- issue_dest  in  ROB_ID_W  destination ROB tag.
- issue_pred  in  1  predicted-taken bit.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  ROB_ID_W  CDB broadcast tag.
- cdb_value  in  16  CDB broadcast value.
- out_valid  out  1  result register full.
- out_ready  in  1  CDB arbiter accepts.
- out_dest  out  ROB_ID_W  result ROB tag.
- out_value  out  16  link value (PC+2 for JSR/JSRR, else 0).
- out_update_pc  out  1  redirect fetch.
- out_new_pc  out  16  redirect address.
- cf_update  out  1  predictor-training strobe.
- cf_pc  out  16  PC of the resolved instruction.
- cf_target  out  16  computed target.
- cf_op  out  4  opcode of the resolved instruction.
- cf_taken  out  1  resolved direction.
- occupancy  out  $clog2(NUM_STATIONS+1)  count of busy entries.

Function
REQ-004 SHALL allocate on issue_valid && issue_ready to the lowest-index free entry; issue_valid while full SHALL be ignored.
REQ-005 SHALL drive issue_ready = 1 whenever occupancy < NUM_STATIONS.
REQ-006 SHALL capture cdb_value into every busy entry whose pending qj/qk matches cdb_tag while cdb_valid=1, and mark that operand ready.
REQ-007 SHALL apply the same-cycle CDB match to the entry being issued (issue bypass), so no broadcast is lost.
REQ-008 SHALL keep an age rank per entry and select the oldest entry with both operands ready.
REQ-009 SHALL select only when out_valid=0, or when out_valid && out_ready in the same cycle, giving back-to-back throughput of one per cycle.
REQ-010 SHALL load the selected entry's result into the output register at the next edge and free that entry at the same edge, giving 1-cycle latency from select to out_valid.
REQ-011 SHALL hold all out_* signals stable while out_valid && !out_ready.
REQ-012 SHALL compute results as follows:
- CF_JUMP (0): taken=1, target=vj.
- CF_JSR (1): taken=1, target=pc+2+vj, value=pc+2.
- CF_JSRR (2): taken=1, target=vj, value=pc+2.
- CF_BRANCH (3): target=pc+2+sext({vk[8:0],0}); taken=(vk[11]&vj[15])|(vk[10]&vj==0)|(vk[9]&!vj[15]&vj!=0).
- Other opcodes: taken=0, target=0, value=0.
REQ-013 SHALL set out_new_pc = taken ? target : pc+2; all arithmetic is 16-bit modulo 2^16, with wrap-around at 0xFFFE+2 = 0x0000.
REQ-014 SHALL pulse cf_update for exactly the cycles where out_valid && out_ready, with cf_* driven from the output register.
REQ-015 SHALL, on flush, clear all entries, ages, out_valid and occupancy at the next edge; flush SHALL override a simultaneous issue, select, or CDB capture.
REQ-016 SHALL give simultaneous issue and select-free a net occupancy change of 0.

Reset
REQ-017 SHALL, while rst_n=0, force every entry free, occupancy=0, out_valid=0, cf_update=0, out_update_pc=0, and zero all out_*/cf_* data outputs; issue_ready=1.
REQ-018 SHALL, on reset mid-operation, discard all in-flight entries and any pending result with no output pulse.

Configuration
REQ-019 SHALL, with macro BRANCH_PREDICTION_EN defined, set out_update_pc = taken != pred (redirect on mispredict only).
REQ-020 SHALL, with BRANCH_PREDICTION_EN undefined, set out_update_pc = taken (static not-taken) and store no pred bits; issue_pred is ignored.

Structure
REQ-021 SHALL place CF opcode constants, the invalid-tag constant and the entry struct typedef (busy, op, pc, vj, vk, qj, qk, dest, pred, age) in lc3b_types.
REQ-022 SHALL instantiate one combinational sub-module, cf_resolve, per selected result (single instance on the select mux output).

Verification
REQ-023 Reset: assert rst_n=0 mid-traffic -> occupancy=0, out_valid=0, issue_ready=1.
REQ-024 BRANCH: pc=0x3000, vk=0x0E10 (nzp, off=0x10), vj=0 -> cf_taken=1, out_new_pc=0x3022, 1 cycle after select.
REQ-025 Wakeup: issue JSRR with qj=3, then cdb_tag=3 value=0x4000 -> out_new_pc=0x4000, out_value=pc+2.
REQ-026 Age order: issue A (qj=5) then B (ready), then broadcast tag 5 -> B out first, then A.
REQ-027 Backpressure/full: fill NUM_STATIONS entries with out_ready=0 -> issue_ready=0, outputs stable; extra issue_valid is dropped.
REQ-028 Flush: flush together with issue and cdb_valid -> next cycle occupancy=0, out_valid=0, no cf_update.
